jt12_timers: RTL and testbench

// - OPN timer A/B pair: consumer of the prescaled FM clock enable (clk_en from the divider).
// - Holds timer registers 0x24-0x27, counts on clk_en, raises flags, IRQ and overflow pulses.
// - Sits between the CPU register interface and the FM core (CSM key-on, status flags).

---
 rtl/jt12_timers_if.sv | 17 +
 rtl/jt12_timers.sv | 143 ++++++++++++++
 tb/tb_jt12_timers.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jt12_timers_if.sv
// Register-write and status bundle between the CPU/FM side and the OPN timer pair.
interface jt12_timers_if;
  logic       clk_en;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] din;
  logic       flag_a;
  logic       flag_b;
  logic       irq_n;
  logic       overflow_a;
  logic       csm_keyon;

  modport master (output clk_en, wr, addr, din,
                  input  flag_a, flag_b, irq_n, overflow_a, csm_keyon);
  modport slave  (input  clk_en, wr, addr, din,
                  output flag_a, flag_b, irq_n, overflow_a, csm_keyon);
endinterface

// File: rtl/jt12_timers.sv
// OPN timer A/B pair (registers 0x24-0x27): counts on clk_en, raises flags, IRQ and overflow pulse.
// Define JT12_TIMER_CSM_EN to enable the CSM key-on pulse on timer A overflow in mode 2'b10.
module jt12_timers #(
  parameter int CNT_A_W = 10,
  parameter int CNT_B_W = 8,
  parameter int PRE_B_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  jt12_timers_if.slave     bus
);

  localparam logic [CNT_A_W-1:0] A_MAX   = {CNT_A_W{1'b1}};
  localparam logic [CNT_B_W-1:0] B_MAX   = {CNT_B_W{1'b1}};
  localparam logic [PRE_B_W-1:0] PRE_MAX = {PRE_B_W{1'b1}};

  logic [CNT_A_W-1:0] value_a_q, value_a_d, cnt_a_q, cnt_a_d;
  logic [CNT_B_W-1:0] value_b_q, value_b_d, cnt_b_q, cnt_b_d;
  logic [PRE_B_W-1:0] pre_b_q, pre_b_d;
  logic               load_a_q, load_a_d, load_b_q, load_b_d;
  logic               en_a_q, en_a_d, en_b_q, en_b_d;
  logic [1:0]         mode_q, mode_d;
  logic               flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic               irq_n_q, irq_n_d, ovf_a_q, ovf_a_d, csm_q, csm_d;
  logic               wr24, wr25, wr26, wr27, evt_a, evt_b;

  always_comb begin
    value_a_d = value_a_q;
    value_b_d = value_b_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    pre_b_d   = pre_b_q;
    load_a_d  = load_a_q;
    load_b_d  = load_b_q;
    en_a_d    = en_a_q;
    en_b_d    = en_b_q;
    mode_d    = mode_q;
    evt_a     = 1'b0;
    evt_b     = 1'b0;

    wr24 = bus.wr && (bus.addr == 2'd0);
    wr25 = bus.wr && (bus.addr == 2'd1);
    wr26 = bus.wr && (bus.addr == 2'd2);
    wr27 = bus.wr && (bus.addr == 2'd3);

    if (wr24) value_a_d[CNT_A_W-1:CNT_A_W-8] = bus.din;
    if (wr25) value_a_d[1:0] = bus.din[1:0];
    if (wr26) value_b_d = bus.din[CNT_B_W-1:0];
    if (wr27) begin
      load_a_d = bus.din[0];
      load_b_d = bus.din[1];
      en_a_d   = bus.din[2];
      en_b_d   = bus.din[3];
      mode_d   = bus.din[7:6];
    end

    // A load rising edge takes priority over a coincident tick
    if (wr27 && bus.din[0] && !load_a_q) begin
      cnt_a_d = value_a_q;
    end else if (load_a_q && bus.clk_en) begin
      if (cnt_a_q == A_MAX) begin
        cnt_a_d = value_a_q;
        evt_a   = 1'b1;
      end else begin
        cnt_a_d = cnt_a_q + CNT_A_W'(1);
      end
    end

    if (wr27 && bus.din[1] && !load_b_q) begin
      cnt_b_d = value_b_q;
      pre_b_d = '0;
    end else if (load_b_q && bus.clk_en) begin
      pre_b_d = pre_b_q + PRE_B_W'(1);
      if (pre_b_q == PRE_MAX) begin
        if (cnt_b_q == B_MAX) begin
          cnt_b_d = value_b_q;
          evt_b   = 1'b1;
        end else begin
          cnt_b_d = cnt_b_q + CNT_B_W'(1);
        end
      end
    end

    // Set has priority over a same-cycle clear
    flag_a_d = flag_a_q;
    if (evt_a && en_a_q)        flag_a_d = 1'b1;
    else if (wr27 && bus.din[4]) flag_a_d = 1'b0;
    flag_b_d = flag_b_q;
    if (evt_b && en_b_q)        flag_b_d = 1'b1;
    else if (wr27 && bus.din[5]) flag_b_d = 1'b0;

    irq_n_d = ~(flag_a_q | flag_b_q);
    ovf_a_d = evt_a;
`ifdef JT12_TIMER_CSM_EN
    csm_d = evt_a && (mode_q == 2'b10);
`else
    csm_d = evt_a & (mode_q == 2'b10) & 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_a_q <= '0;
      value_b_q <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      pre_b_q   <= '0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      en_a_q    <= 1'b0;
      en_b_q    <= 1'b0;
      mode_q    <= 2'b00;
      flag_a_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      irq_n_q   <= 1'b1;
      ovf_a_q   <= 1'b0;
      csm_q     <= 1'b0;
    end else begin
      value_a_q <= value_a_d;
      value_b_q <= value_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      pre_b_q   <= pre_b_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      en_a_q    <= en_a_d;
      en_b_q    <= en_b_d;
      mode_q    <= mode_d;
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      irq_n_q   <= irq_n_d;
      ovf_a_q   <= ovf_a_d;
      csm_q     <= csm_d;
    end
  end

  assign bus.flag_a     = flag_a_q;
  assign bus.flag_b     = flag_b_q;
  assign bus.irq_n      = irq_n_q;
  assign bus.overflow_a = ovf_a_q;
  assign bus.csm_keyon  = csm_q;

endmodule

// File: tb/tb_jt12_timers.sv
// Directed bench for jt12_timers: cycle table for timer A, hand sequences for B, reset and CSM.
module tb_jt12_timers;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  jt12_timers_if bus ();

  jt12_timers dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef JT12_TIMER_CSM_EN
  localparam logic CSM_EXP = 1'b1;
`else
  localparam logic CSM_EXP = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic       ce;
    logic       fa;
    logic       fb;
    logic       irq;
    logic       ov;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d, input logic ce);
    bus.wr = w; bus.addr = a; bus.din = d; bus.clk_en = ce;
    @(posedge clk); #1;
    bus.wr = 1'b0; bus.clk_en = 1'b0;
  endtask

  task automatic chk_all(input string nm, input logic fa, input logic fb, input logic irq,
                         input logic ov, input logic csm);
    chk({nm, "_flag_a"}, bus.flag_a, fa);
    chk({nm, "_flag_b"}, bus.flag_b, fb);
    chk({nm, "_irq_n"}, bus.irq_n, irq);
    chk({nm, "_ovf_a"}, bus.overflow_a, ov);
    chk({nm, "_csm"}, bus.csm_keyon, csm);
  endtask

  // clk_en on every second cycle until flag_b rises; count ticks delivered
  task automatic run_b(input int exp_ticks, input string nm);
    int  ticks = 0;
    bit  seen = 0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      logic ce;
      ce = (cyc % 2 == 0);
      step(1'b0, 2'd0, 8'h00, ce);
      if (ce) ticks++;
      if (bus.flag_b) seen = 1;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_ticks"}, ticks, exp_ticks);
    chk({nm, "_irq_lag"}, bus.irq_n, 1);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    chk({nm, "_irq"}, bus.irq_n, 0);
  endtask

  initial begin
    int ovs;
    // wr addr din ce | fa fb irq ov
    vecs[0]  = '{1, 2'd0, 8'hFF, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 2'd1, 8'h00, 0, 0, 0, 1, 0};
    vecs[2]  = '{1, 2'd3, 8'h05, 1, 0, 0, 1, 0};
    vecs[3]  = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 0};
    vecs[4]  = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 0};
    vecs[5]  = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 2'd0, 8'h00, 1, 1, 0, 1, 1};
    vecs[7]  = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 0};
    vecs[8]  = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 0};
    vecs[9]  = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 0};
    vecs[10] = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 1};
    vecs[11] = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 0};
    vecs[12] = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 0};
    vecs[13] = '{0, 2'd0, 8'h00, 1, 1, 0, 0, 0};
    vecs[14] = '{1, 2'd3, 8'h15, 1, 1, 0, 0, 1};
    vecs[15] = '{1, 2'd3, 8'h15, 0, 0, 0, 0, 0};
    vecs[16] = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0};
    vecs[17] = '{1, 2'd3, 8'h01, 1, 0, 0, 1, 0};
    vecs[18] = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 0};
    vecs[19] = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 0};
    vecs[20] = '{0, 2'd0, 8'h00, 1, 0, 0, 1, 1};
    vecs[21] = '{0, 2'd0, 8'h00, 0, 0, 0, 1, 0};

    bus.wr = 0; bus.addr = 0; bus.din = 0; bus.clk_en = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 1, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].ce);
      chk_all($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].irq, vecs[i].ov, 1'b0);
    end

    // Timer B: 255 -> 16 ticks, then 254 -> 32 ticks
    step(1, 2'd2, 8'hFF, 0);
    step(1, 2'd3, 8'h0A, 0);
    run_b(16, "b255");
    step(1, 2'd3, 8'h20, 0);
    chk("b_clear", bus.flag_b, 0);
    step(1, 2'd2, 8'hFE, 0);
    step(1, 2'd3, 8'h0A, 0);
    run_b(32, "b254");

    // Reset in the middle of counting
    step(1, 2'd3, 8'h00, 0);
    step(1, 2'd3, 8'h05, 0);
    repeat (4) step(0, 2'd0, 8'h00, 1);
    chk("pre_rst_flag_a", bus.flag_a, 1);
    repeat (2) step(0, 2'd0, 8'h00, 1);
    rst_n = 1'b0;
    step(0, 2'd0, 8'h00, 1);
    rst_n = 1'b1;
    chk_all("midrst", 0, 0, 1, 0, 0);
    ovs = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 2'd0, 8'h00, 1);
      if (bus.overflow_a || bus.flag_a || bus.flag_b) ovs++;
    end
    chk("post_rst_quiet", ovs, 0);

    // CSM key-on in mode 2, then mode 0
    step(1, 2'd0, 8'hFF, 0);
    step(1, 2'd1, 8'h00, 0);
    step(1, 2'd3, 8'h81, 0);
    repeat (3) step(0, 2'd0, 8'h00, 1);
    chk("csm2_pre", bus.csm_keyon, 0);
    step(0, 2'd0, 8'h00, 1);
    chk("csm2_ovf", bus.overflow_a, 1);
    chk("csm2_key", bus.csm_keyon, CSM_EXP);
    step(0, 2'd0, 8'h00, 0);
    chk("csm2_after", bus.csm_keyon, 0);
    step(1, 2'd3, 8'h00, 0);
    step(1, 2'd3, 8'h01, 0);
    repeat (4) step(0, 2'd0, 8'h00, 1);
    chk("csm0_ovf", bus.overflow_a, 1);
    chk("csm0_key", bus.csm_keyon, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
